// File: rtl/mem_port_sched_if.sv
// Bundle of IF/MEM pipeline requests, the unified memory port, and the
// pipeline-side results of mem_port_sched.
//   slave  : the scheduler's view. Pipeline requests and the memory response
//            are inputs; the port request, stall, instruction, load data and
//            stall counter are outputs.
//   master : the environment's view (pipeline + memory), directions mirrored.
interface mem_port_sched_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          port_req;
    logic          port_we;
    logic [AW-1:0] port_addr;
    logic [DW-1:0] port_wdata;
    logic          port_ack;
    logic [DW-1:0] port_rdata;
    logic          pipe_stall;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic [DW-1:0] ld_data;
    logic [15:0]   stall_cnt;

    modport slave (
        input  fetch_en, fetch_addr, mem_valid, mem_we, mem_addr, mem_wdata,
        input  port_ack, port_rdata,
        output port_req, port_we, port_addr, port_wdata,
        output pipe_stall, instr, instr_valid, ld_data, stall_cnt
    );

    modport master (
        output fetch_en, fetch_addr, mem_valid, mem_we, mem_addr, mem_wdata,
        output port_ack, port_rdata,
        input  port_req, port_we, port_addr, port_wdata,
        input  pipe_stall, instr, instr_valid, ld_data, stall_cnt
    );
endinterface

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler shared by instruction fetch (IF) and data
// access (MEM). The data access wins the port because it belongs to the
// older instruction. Per pipeline step the block remembers which accesses
// have already completed, stalls the pipeline until every requested access
// is done, and holds returned instruction/load data until the step advances.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_port_sched_if.slave: fetch/data requests, memory port
//          (req/we/addr/wdata out, ack/rdata in), pipe_stall, instr,
//          instr_valid, ld_data and the saturating stall_cnt.
module mem_port_sched #(
    parameter int            AW  = 12,
    parameter int            DW  = 32,
    parameter logic [DW-1:0] NOP = 32'h00000033
) (
    input logic             clk,
    input logic             rst,
    mem_port_sched_if.slave bus
);
    // Step progress as {data_done, fetch_done}; 2'b11 is never held because
    // the step advances in the same cycle the last access completes.
    localparam logic [1:0] STEP_START = 2'b00;
    localparam logic [1:0] DATA_DONE  = 2'b10;
    localparam logic [1:0] FETCH_DONE = 2'b01;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] instr_q;
    logic [DW-1:0] ld_q;
    logic [15:0]   stall_cnt_q;

    logic data_done, fetch_done;
    logic need_data, need_fetch;
    logic sel_data, sel_fetch;
    logic ack_data, ack_fetch;
    logic advance;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign data_done  = |(state_q & DATA_DONE);
    assign fetch_done = |(state_q & FETCH_DONE);

    assign need_data  = bus.mem_valid & ~data_done;
    assign need_fetch = bus.fetch_en & ~fetch_done;
    assign sel_data   = need_data;
    assign sel_fetch  = ~need_data & need_fetch;

    // An ack only counts for the access actually presented; an ack with no
    // request falls through both terms and is ignored.
    assign ack_data   = sel_data & bus.port_ack;
    assign ack_fetch  = sel_fetch & bus.port_ack;

    assign advance    = (~need_data | ack_data) & (~need_fetch | ack_fetch);

    assign bus.port_req   = sel_data | sel_fetch;
    assign bus.port_we    = sel_data & bus.mem_we;
    assign bus.port_addr  = sel_data ? bus.mem_addr : bus.fetch_addr;
    assign bus.port_wdata = bus.mem_wdata;

    assign bus.pipe_stall  = ~advance;
    assign bus.instr_valid = advance & bus.fetch_en;
    assign bus.stall_cnt   = stall_cnt_q;

    // Bypass so the pipeline sees returned data in the same cycle the step
    // completes, without waiting for the holding register.
    assign bus.instr   = ack_fetch ? bus.port_rdata : instr_q;
    assign bus.ld_data = (ack_data & ~bus.mem_we) ? bus.port_rdata : ld_q;

    // Advancing wins over marking an access done: the next step starts clean.
    always_comb begin
        state_d = state_q;
        if (ack_data)
            state_d = state_d | DATA_DONE;
        if (ack_fetch)
            state_d = state_d | FETCH_DONE;
        if (advance)
            state_d = STEP_START;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STEP_START;
            instr_q     <= NOP;
            ld_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (ack_fetch)
                instr_q <= bus.port_rdata;
            if (ack_data && !bus.mem_we)
                ld_q <= bus.port_rdata;
            if (!advance)
                stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end
endmodule

// File: tb/tb_mem_port_sched.sv
module tb_mem_port_sched;
    localparam int          AW  = 12;
    localparam int          DW  = 32;
    localparam logic [31:0] NOP = 32'h00000033;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_sched_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_sched #(.AW(AW), .DW(DW), .NOP(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fe, input logic mv, input logic we,
                         input logic [AW-1:0] fa, input logic [AW-1:0] ma,
                         input logic [31:0] wd, input logic ack, input logic [31:0] rd);
        bus.fetch_en   = fe;
        bus.mem_valid  = mv;
        bus.mem_we     = we;
        bus.fetch_addr = fa;
        bus.mem_addr   = ma;
        bus.mem_wdata  = wd;
        bus.port_ack   = ack;
        bus.port_rdata = rd;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    typedef struct {
        logic          fe, mv, we;
        logic [AW-1:0] fa, ma;
        logic [31:0]   wd;
        logic          ack;
        logic [31:0]   rd;
        logic          e_req, e_we;
        logic [AW-1:0] e_addr;
        logic          e_stall, e_iv;
        logic [31:0]   e_instr, e_ld;
    } vec_t;

    vec_t tbl[9];

    // reference-model state for the random phase
    bit          pend[$];   // outstanding accesses of this step, 1 = data, 0 = fetch
    logic [31:0] m_instr, m_ld;
    logic [15:0] m_cnt;

    initial begin
        logic pat[7];
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        #1;
        chk("rst_instr", bus.instr, NOP);
        chk("rst_ld", bus.ld_data, 32'h0);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("rst_stall", 32'(bus.pipe_stall), 32'h0);
        rst = 1'b0;
        tick();

        // ---------------- single-cycle table from step start ----------------
        tbl[0] = '{1'b1,1'b0,1'b0,12'h005,12'h100,32'h11,1'b1,32'h00A00093, 1'b1,1'b0,12'h005,1'b0,1'b1,32'h00A00093,32'h0};
        tbl[1] = '{1'b1,1'b0,1'b0,12'h005,12'h100,32'h11,1'b0,32'h00000BAD, 1'b1,1'b0,12'h005,1'b1,1'b0,NOP,32'h0};
        tbl[2] = '{1'b1,1'b1,1'b0,12'h006,12'h200,32'h22,1'b1,32'hDEADBEEF, 1'b1,1'b0,12'h200,1'b1,1'b0,NOP,32'hDEADBEEF};
        tbl[3] = '{1'b1,1'b1,1'b1,12'h006,12'h201,32'hCAFE,1'b1,32'h1234,   1'b1,1'b1,12'h201,1'b1,1'b0,NOP,32'h0};
        tbl[4] = '{1'b0,1'b0,1'b0,12'h007,12'h202,32'h33,1'b1,32'h5555,     1'b0,1'b0,12'h007,1'b0,1'b0,NOP,32'h0};
        tbl[5] = '{1'b0,1'b1,1'b0,12'h008,12'h300,32'h44,1'b1,32'h77,       1'b1,1'b0,12'h300,1'b0,1'b0,NOP,32'h77};
        tbl[6] = '{1'b0,1'b1,1'b0,12'h008,12'h301,32'h45,1'b0,32'h78,       1'b1,1'b0,12'h301,1'b1,1'b0,NOP,32'h0};
        tbl[7] = '{1'b0,1'b1,1'b1,12'h008,12'h302,32'h46,1'b1,32'h88,       1'b1,1'b1,12'h302,1'b0,1'b0,NOP,32'h0};
        tbl[8] = '{1'b1,1'b1,1'b1,12'h009,12'h303,32'h47,1'b0,32'h99,       1'b1,1'b1,12'h303,1'b1,1'b0,NOP,32'h0};
        for (int i = 0; i < 9; i++) begin
            do_reset();
            drive(tbl[i].fe, tbl[i].mv, tbl[i].we, tbl[i].fa, tbl[i].ma, tbl[i].wd, tbl[i].ack, tbl[i].rd);
            #1;
            chk($sformatf("tbl%0d_req", i),   32'(bus.port_req),    32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_we", i),    32'(bus.port_we),     32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_addr", i),  32'(bus.port_addr),   32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_wdata", i), bus.port_wdata,       tbl[i].wd);
            chk($sformatf("tbl%0d_stall", i), 32'(bus.pipe_stall),  32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_iv", i),    32'(bus.instr_valid), 32'(tbl[i].e_iv));
            chk($sformatf("tbl%0d_instr", i), bus.instr,            tbl[i].e_instr);
            chk($sformatf("tbl%0d_ld", i),    bus.ld_data,          tbl[i].e_ld);
            tick();
        end

        // ---------------- reset in the middle of a step ----------------
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 12'h010, 12'h020, 32'h0, 1'b1, 32'hAAAA5555);
        tick();
        bus.port_ack = 1'b0;
        #1;
        chk("mid_pre_addr", 32'(bus.port_addr), 32'h010);
        chk("mid_pre_ld", bus.ld_data, 32'hAAAA5555);
        rst = 1'b1;
        #1;
        chk("mid_rst_addr", 32'(bus.port_addr), 32'h020);
        chk("mid_rst_instr", bus.instr, NOP);
        chk("mid_rst_ld", bus.ld_data, 32'h0);
        chk("mid_rst_cnt", 32'(bus.stall_cnt), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rel_req", 32'(bus.port_req), 32'h1);
        chk("mid_rel_addr", 32'(bus.port_addr), 32'h020);
        tick();

        // ---------------- fetch only, zero wait ----------------
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 12'h005, 12'h000, 32'h0, 1'b1, 32'h00A00093);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fo_stall", 32'(bus.pipe_stall), 32'h0);
            chk("fo_instr", bus.instr, 32'h00A00093);
            chk("fo_iv", 32'(bus.instr_valid), 32'h1);
            chk("fo_addr", 32'(bus.port_addr), 32'h005);
            tick();
        end
        chk("fo_cnt", 32'(bus.stall_cnt), 32'h0);

        // ---------------- load + fetch, zero wait ----------------
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 12'h040, 12'h050, 32'h0, 1'b1, 32'hDEADBEEF);
        #1;
        chk("lf1_addr", 32'(bus.port_addr), 32'h050);
        chk("lf1_stall", 32'(bus.pipe_stall), 32'h1);
        chk("lf1_iv", 32'(bus.instr_valid), 32'h0);
        tick();
        bus.port_rdata = 32'h00000013;
        #1;
        chk("lf2_addr", 32'(bus.port_addr), 32'h040);
        chk("lf2_we", 32'(bus.port_we), 32'h0);
        chk("lf2_stall", 32'(bus.pipe_stall), 32'h0);
        chk("lf2_ld", bus.ld_data, 32'hDEADBEEF);
        chk("lf2_instr", bus.instr, 32'h00000013);
        chk("lf2_iv", 32'(bus.instr_valid), 32'h1);
        tick();
        chk("lf_cnt", 32'(bus.stall_cnt), 32'h1);

        // ---------------- store 3 waits, fetch 2 waits ----------------
        do_reset();
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        drive(1'b1, 1'b1, 1'b1, 12'h060, 12'h070, 32'h12345678, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            bus.port_ack = pat[i];
            #1;
            chk($sformatf("sw%0d_we", i), 32'(bus.port_we), (i < 4) ? 32'h1 : 32'h0);
            chk($sformatf("sw%0d_stall", i), 32'(bus.pipe_stall), (i < 6) ? 32'h1 : 32'h0);
            tick();
        end
        chk("sw_cnt", 32'(bus.stall_cnt), 32'h6);

        // ---------------- load only, ack on 2nd cycle ----------------
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 12'h000, 12'h080, 32'h0, 1'b0, 32'h99);
        #1;
        chk("lo1_stall", 32'(bus.pipe_stall), 32'h1);
        tick();
        bus.port_ack = 1'b1;
        #1;
        chk("lo2_stall", 32'(bus.pipe_stall), 32'h0);
        chk("lo2_iv", 32'(bus.instr_valid), 32'h0);
        chk("lo2_ld", bus.ld_data, 32'h99);
        tick();
        chk("lo_cnt", 32'(bus.stall_cnt), 32'h1);

        // ---------------- randomized steps against a queue model ----------------
        do_reset();
        m_instr = NOP;
        m_ld    = 32'h0;
        m_cnt   = 16'h0;
        for (int s = 0; s < 400; s++) begin
            logic          fe, mv, we;
            logic [AW-1:0] fa, ma;
            logic [31:0]   wd;
            int            waits;
            bit            first;
            fe = 1'($urandom_range(0, 1));
            mv = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            fa = AW'($urandom);
            ma = AW'($urandom);
            wd = $urandom;
            pend.delete();
            if (mv) pend.push_back(1'b1);
            if (fe) pend.push_back(1'b0);
            waits = 0;
            first = 1'b1;
            while (first || pend.size() > 0) begin
                logic        ack, have_req, head_data, acked, e_stall;
                logic [31:0] rd, e_instr, e_ld;
                int          remain;
                first = 1'b0;
                ack = (waits >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
                rd  = $urandom;
                drive(fe, mv, we, fa, ma, wd, ack, rd);
                #1;
                have_req  = pend.size() > 0;
                head_data = have_req && pend[0];
                acked     = have_req && ack;
                remain    = pend.size() - (acked ? 1 : 0);
                e_stall   = remain > 0;
                e_instr   = (acked && !head_data) ? rd : m_instr;
                e_ld      = (acked && head_data && !we) ? rd : m_ld;
                chk("rnd_req",   32'(bus.port_req),    32'(have_req));
                chk("rnd_we",    32'(bus.port_we),     32'(head_data && we));
                chk("rnd_addr",  32'(bus.port_addr),   head_data ? 32'(ma) : 32'(fa));
                chk("rnd_wdata", bus.port_wdata,       wd);
                chk("rnd_stall", 32'(bus.pipe_stall),  32'(e_stall));
                chk("rnd_iv",    32'(bus.instr_valid), 32'(!e_stall && fe));
                chk("rnd_instr", bus.instr,            e_instr);
                chk("rnd_ld",    bus.ld_data,          e_ld);
                chk("rnd_cnt",   32'(bus.stall_cnt),   32'(m_cnt));
                tick();
                if (acked) begin
                    if (head_data) begin
                        if (!we) m_ld = rd;
                    end else begin
                        m_instr = rd;
                    end
                    void'(pend.pop_front());
                end
                if (e_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                waits++;
            end
        end

        // ---------------- stall counter saturation ----------------
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 12'h000, 12'h0AA, 32'h0, 1'b0, 32'h0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(bus.stall_cnt), 32'h0000FFFE);
        tick();
        chk("sat_ffff", 32'(bus.stall_cnt), 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold", 32'(bus.stall_cnt), 32'h0000FFFF);
        chk("sat_stall", 32'(bus.pipe_stall), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Single-ported memory scheduler for the pipelined CPU. Instruction fetch (IF stage) and data access (MEM stage) share one unified memory port. The block grants the port to one stage at a time and tracks which accesses of the current pipeline step are complete. It drives the global pipeline stall and holds returned instruction and load data in registers until the whole pipeline advances.

## Interface
- AW, 12, memory word-address width
- DW, 32, data/instruction width
- NOP, 32'h00000033, instruction value driven after reset (add x0,x0,x0)
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- fetch_en  in  1  IF stage requests an instruction this step
- fetch_addr  in  AW  PC word address, held stable while pipe_stall=1
- mem_valid  in  1  MEM stage holds a load or store
- mem_we  in  1  1=store, 0=load
- mem_addr  in  AW  data word address, stable while pipe_stall=1
- mem_wdata  in  DW  store data
- port_req  out  1  access request to memory
- port_we  out  1  write enable to memory
- port_addr  out  AW  address to memory
- port_wdata  out  DW  write data to memory
- port_ack  in  1  memory completes the presented access this cycle (may be same cycle as port_req)
- port_rdata  in  DW  read data, valid when port_ack=1
- pipe_stall  out  1  hold all pipeline registers and PC
- instr  out  DW  instruction for IF/ID register
- instr_valid  out  1  instr belongs to this step (0 → IF/ID takes bubble)
- ld_data  out  DW  load data for MEM/WB register
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
- State: two registered flags, data_done and fetch_done. Equivalent FSM: STEP_START (00), DATA_DONE (10), FETCH_DONE (01). State 11 is never held, because the step advances at that point.
- need_data = mem_valid & ~data_done. need_fetch = fetch_en & ~fetch_done.
- Grant: the data access has priority because it belongs to the older instruction.
  - sel_data = need_data.
  - sel_fetch = ~need_data & need_fetch.
- Port, all combinational:
  - port_req = sel_data | sel_fetch.
  - sel_data: port_addr=mem_addr, port_we=mem_we, port_wdata=mem_wdata.
  - Otherwise: port_addr=fetch_addr, port_we=0, port_wdata=mem_wdata.
- Advance condition: advance = (~need_data | (sel_data & port_ack)) & (~need_fetch | (sel_fetch & port_ack)). pipe_stall = ~advance.
- When neither stage needs the port, advance=1 every cycle and port_req=0.
- On port_ack with sel_data:
  - Set data_done.
  - For a load, capture port_rdata into ld_q.
- On port_ack with sel_fetch:
  - Set fetch_done.
  - Capture port_rdata into instr_q.
- On advance: clear both flags at the clock edge. This takes priority over any set.
- Output bypass:
  - instr = (sel_fetch & port_ack) ? port_rdata : instr_q.
  - ld_data = (sel_data & port_ack & ~mem_we) ? port_rdata : ld_q.
  - instr_valid = advance & fetch_en.
- stall_cnt: increments by 1 on every clock with pipe_stall=1, saturates at 16'hFFFF, never wraps.

## Timing
- Reset values (rst asynchronous): data_done=0, fetch_done=0, instr_q=NOP, ld_q=0, stall_cnt=0.
- With rst asserted, ports and stall are still derived combinationally from inputs; there is no flag state.
- Zero-wait memory (port_ack=1 whenever requested):
  - Fetch-only step: 1 cycle, no stall.
  - Load/store + fetch step: 2 cycles, 1 stall cycle. Data completes in cycle 1, fetch in cycle 2.
- Wait states: a step takes (data cycles + fetch cycles). Stall count = total − 1.
- port_ack while port_req=0 is ignored.
- mem_valid or fetch_en dropping mid-step (not legal while stalled): the block still advances per the formula. There is no error state.
- Reset mid-access: flags clear immediately. The aborted access is re-requested from STEP_START after rst falls.

## Test plan
- Reset: assert rst mid-access with data_done=1 → flags 0, instr=NOP (ack low), ld_data=0, stall_cnt=0. Release with mem_valid=1 → port_req=1, port_addr=mem_addr.
- Fetch only, port_ack tied 1, port_rdata=0x00A00093, fetch_addr=5 → every cycle pipe_stall=0, instr=0x00A00093, instr_valid=1, port_addr=5.
- Load + fetch, ack tied 1:
  - Cycle 1: port_addr=mem_addr, port_rdata=0xDEADBEEF, pipe_stall=1.
  - Cycle 2: port_addr=fetch_addr, rdata=0x13, pipe_stall=0, ld_data=0xDEADBEEF, instr=0x13.
  - Result: stall_cnt=1.
- Store with 3 wait states, then fetch with 2 wait states:
  - Store: port_we=1 for 4 cycles.
  - Fetch: port_we=0 for 3 cycles.
  - Result: pipe_stall=1 for 6 cycles then 0, stall_cnt += 6.
- mem_valid=1, fetch_en=0, ack on 2nd cycle → 1 stall, instr_valid=0 on advance.
- stall_cnt preset near 16'hFFFE by holding ack=0 for 65536+ cycles → value stays 16'hFFFF.
